// File: rtl/dbus_pkg.sv
// dbus_pkg: shared constants, FSM state encoding and address helper for the
// data-cache memory-bus controller (dbus_ctrl, dbus_wbuf).
//   LINE_W      : cache line width in bits
//   LINE_OFFS_W : byte-offset bits inside a line
//   ADDR_W      : address width
package dbus_pkg;

    localparam int unsigned LINE_W      = 1024;
    localparam int unsigned LINE_OFFS_W = 7;
    localparam int unsigned ADDR_W      = 64;

    typedef logic [1:0] dbus_state_t;

    localparam dbus_state_t ST_IDLE     = 2'd0;
    localparam dbus_state_t ST_WR_BURST = 2'd1;
    localparam dbus_state_t ST_RD_BURST = 2'd2;
    localparam dbus_state_t ST_RD_DONE  = 2'd3;

    // Byte address of the first beat of the line containing addr.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFS_W], {LINE_OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dbus_wbuf.sv
// dbus_wbuf: single-entry write-through buffer for dbus_ctrl.
// Ports:
//   clk, clr_n          : clock, asynchronous active-low reset
//   wr, wr_addr, wr_data: write-through request (one-cycle pulse) and payload
//   drained             : burst controller has completed the last write beat
//   valid               : buffer holds a line awaiting drain
//   buf_addr, buf_data  : buffered line base address and data
//   ovf                 : sticky, a write arrived while the buffer was full
module dbus_wbuf
    import dbus_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              drained,
    output logic              valid,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [LINE_W-1:0] buf_data,
    output logic              ovf
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid    <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            ovf      <= 1'b0;
        end else begin
            if (drained) begin
                valid <= 1'b0;
            end
            // A write in the same cycle as the final drain beat still sees
            // the buffer full and is dropped.
            if (wr) begin
                if (valid) begin
                    ovf <= 1'b1;
                end else begin
                    valid    <= 1'b1;
                    buf_addr <= line_base(wr_addr);
                    buf_data <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-cache line-fill / write-through controller driving a
// beat-level memory bus of BUS_W bits (BEATS = 1024/BUS_W beats per line).
// Optional feature: define DBUS_WBUF_FWD_EN to let a line fill that hits the
// pending write buffer be served from the buffer without a bus read.
// Ports:
//   clk, clr_n                 : clock, asynchronous active-low reset
//   c_addr, c_rd, c_dv, c_rdata: cache line-fill request / completion
//   c_wr, c_wdata              : cache write-through pulse and line data
//   c_wr_rdy, c_wr_ovf         : write buffer empty, sticky write overflow
//   m_addr, m_req, m_we, m_wdata, m_rdata, m_ack : memory bus beats
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int unsigned BUS_W = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_rd,
    output logic              c_dv,
    output logic [LINE_W-1:0] c_rdata,
    input  logic              c_wr,
    input  logic [LINE_W-1:0] c_wdata,
    output logic              c_wr_rdy,
    output logic              c_wr_ovf,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_req,
    output logic              m_we,
    output logic [BUS_W-1:0]  m_wdata,
    input  logic [BUS_W-1:0]  m_rdata,
    input  logic              m_ack
);

    localparam int unsigned BEATS = LINE_W / BUS_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(BUS_W / 8);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEATS - 1);

    dbus_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              wb_drained;

    logic              beat_done;
    logic              last_beat;
    logic              rd_go;
    logic              fwd_hit;

    dbus_wbuf u_wbuf (
        .clk      (clk),
        .clr_n    (clr_n),
        .wr       (c_wr),
        .wr_addr  (c_addr),
        .wr_data  (c_wdata),
        .drained  (wb_drained),
        .valid    (wb_valid),
        .buf_addr (wb_addr),
        .buf_data (wb_data),
        .ovf      (c_wr_ovf)
    );

    assign c_wr_rdy   = ~wb_valid;
    assign beat_done  = m_req & m_ack;
    assign last_beat  = (cnt == CNT_LAST);
    assign cnt_nxt    = cnt + CNT_W'(1);
    assign wb_drained = (state == ST_WR_BURST) & beat_done & last_beat;

    // A read may start only when no write is being accepted this cycle (so a
    // simultaneous write drains first) and not in the completion-pulse cycle,
    // which gives the caller that cycle to drop c_rd.
    assign rd_go = c_rd & ~c_dv & ~(c_wr & ~wb_valid);

`ifdef DBUS_WBUF_FWD_EN
    assign fwd_hit = wb_valid &
                     (wb_addr[ADDR_W-1:LINE_OFFS_W] == c_addr[ADDR_W-1:LINE_OFFS_W]);
`else
    assign fwd_hit = 1'b0;
`endif

    // c_dv is registered on leaving RD_DONE, so the pulse lands in the cycle
    // after RD_DONE; the line register is already final by then.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_dv    <= 1'b0;
            c_rdata <= '0;
        end else begin
            c_dv <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_go && fwd_hit) begin
                        c_rdata <= wb_data;
                        state   <= ST_RD_DONE;
                    end else if (wb_valid) begin
                        state   <= ST_WR_BURST;
                        cnt     <= '0;
                        m_req   <= 1'b1;
                        m_we    <= 1'b1;
                        m_addr  <= wb_addr;
                        m_wdata <= wb_data[BUS_W-1:0];
                    end else if (rd_go) begin
                        state  <= ST_RD_BURST;
                        cnt    <= '0;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= line_base(c_addr);
                    end
                end

                ST_WR_BURST: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            m_req <= 1'b0;
                            m_we  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt     <= cnt_nxt;
                            m_addr  <= m_addr + BEAT_INC;
                            m_wdata <= wb_data[32'(cnt_nxt) * BUS_W +: BUS_W];
                        end
                    end
                end

                ST_RD_BURST: begin
                    if (beat_done) begin
                        c_rdata[32'(cnt) * BUS_W +: BUS_W] <= m_rdata;
                        if (last_beat) begin
                            m_req <= 1'b0;
                            state <= ST_RD_DONE;
                        end else begin
                            cnt    <= cnt_nxt;
                            m_addr <= m_addr + BEAT_INC;
                        end
                    end
                end

                ST_RD_DONE: begin
                    c_dv  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 SHALL have parameter BUS_W, default 64: memory data-bus width; power of two, 64..512, divides 1024.
REQ-002 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-003 SHALL have port clr_n  in  1: reset, asynchronous, active-low.
REQ-004 SHALL have port c_addr  in  64: cache-line address from data cache; bits [6:0] ignored.
REQ-005 SHALL have port c_rd  in  1: line-fill request, level, held until c_dv.
REQ-006 SHALL have port c_dv  out  1: one-cycle pulse, c_rdata valid.
REQ-007 SHALL have port c_rdata  out  1024: filled line.
REQ-008 SHALL have port c_wr  in  1: one-cycle write-through pulse; c_addr/c_wdata sampled same cycle.
REQ-009 SHALL have port c_wdata  in  1024: line to write.
REQ-010 SHALL have port c_wr_rdy  out  1: write buffer empty.
REQ-011 SHALL have port c_wr_ovf  out  1: sticky, c_wr seen while c_wr_rdy=0.
REQ-012 SHALL have ports m_addr out 64, m_req out 1, m_we out 1, m_wdata out BUS_W, m_rdata in BUS_W, m_ack in 1: beat-level memory bus.

Function
REQ-013 SHALL use BEATS = 1024/BUS_W; beat k address = {c_addr[63:7],7'b0} + k*(BUS_W/8); beat k carries line bits [k*BUS_W +: BUS_W].
REQ-014 SHALL hold m_req, m_we, m_addr, m_wdata stable until m_ack; a beat completes on the cycle m_ack=1 and m_req=1; next beat's m_req may assert the following cycle.
REQ-015 SHALL capture m_rdata into the line register on each read-beat m_ack; m_ack while m_req=0 ignored.
REQ-016 SHALL implement FSM IDLE, WR_BURST, RD_BURST, RD_DONE.
REQ-017 IDLE: write buffer valid -> WR_BURST (priority); else c_rd -> RD_BURST; else stay.
REQ-018 WR_BURST: issue BEATS write beats from buffer; on last ack clear buffer, -> IDLE.
REQ-019 RD_BURST: issue BEATS read beats at c_addr latched on entry; on last ack -> RD_DONE.
REQ-020 RD_DONE: c_dv=1 for exactly one cycle with c_rdata; -> IDLE; c_rd must be deasserted by caller the next cycle, else a new fill starts.
REQ-021 Beat counter SHALL be log2(BEATS) bits, zeroed on burst entry, last beat when counter = BEATS-1.
REQ-022 c_wr with buffer empty SHALL load buffer (addr, data) that cycle; c_wr_rdy low from next cycle until buffer drained.
REQ-023 c_wr with buffer full SHALL be dropped and set c_wr_ovf; buffer contents unchanged.
REQ-024 c_wr and c_rd in same cycle SHALL load the buffer and drain it before the read.
REQ-025 Minimum read latency, c_rd rise to c_dv, with m_ack tied 1 and empty buffer SHALL be BEATS+2 cycles.

Reset
REQ-026 clr_n low SHALL immediately force IDLE, counter 0, buffer invalid, m_req=0, m_we=0, m_addr=0, m_wdata=0, c_dv=0, c_rdata=0, c_wr_rdy=1, c_wr_ovf=0; burst in flight abandoned, no completion pulse.

Configuration
REQ-027 Macro DBUS_WBUF_FWD_EN defined: in IDLE, c_rd with valid buffer whose line address equals c_addr[63:7] SHALL skip the bus, load c_rdata from buffer, go RD_DONE next cycle; buffer still drained afterwards.
REQ-028 Macro undefined: no forwarding; such reads wait for the drain per REQ-017.

Structure
REQ-029 Package dbus_pkg SHALL hold LINE_W=1024, LINE_OFFS_W=7, FSM state typedef.
REQ-030 Write buffer (valid, addr, data, ovf logic) SHALL be sub-module dbus_wbuf.

Verification
REQ-031 BUS_W=64, m_ack=1, c_rd at 0x1000 -> 16 reads 0x1000..0x1078, c_dv at cycle 18, c_rdata beat k = m_rdata k.
REQ-032 c_wr 0x2080, data pattern, m_ack every 3rd cycle -> 16 writes in order, c_wr_rdy returns 1 after last ack.
REQ-033 c_wr 0x3000 and c_rd 0x4000 same cycle -> all write beats precede first read beat.
REQ-034 second c_wr during drain -> c_wr_ovf=1, bus data equals first line only.
REQ-035 clr_n low at read beat 7 -> all outputs at reset values, no c_dv; new c_rd completes normally.
REQ-036 FWD_EN: c_wr 0x5000 then c_rd 0x5000 -> c_dv 2 cycles after c_rd with written line; undefined: c_dv after drain+fill.
